huffman_dec_pack: RTL and testbench

//  Parametrised serial Huffman decoder with a run-time programmable code table. Consumes one

---
 rtl/huffman_dec_pack_pkg.sv | 24 ++
 rtl/huffman_dec_pack_if.sv | 39 +++
 rtl/huffman_dec_pack_code_table.sv | 57 +++++
 rtl/huffman_dec_pack.sv | 149 ++++++++++++++
 tb/tb_huffman_dec_pack.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/huffman_dec_pack_pkg.sv
// Shared types and constants for the Huffman decoder / row packer.
//   MAX_LEN_DEF   default longest code length
//   MAX_LEN_LIMIT widest code the table storage supports
//   LEN_W/CNT_W   widths of a stored code length and of the default bit counter
//   entry_t       one code-table entry {len, code}
package huffman_dec_pack_pkg;

  localparam int unsigned MAX_LEN_DEF   = 8;
  localparam int unsigned MAX_LEN_LIMIT = 16;
  localparam int unsigned LEN_W         = $clog2(MAX_LEN_LIMIT + 1);
  localparam int unsigned CNT_W         = $clog2(MAX_LEN_DEF + 1);

  // Entries are stored at the widest supported size; narrower configs zero-extend.
  typedef struct packed {
    logic [LEN_W-1:0]         len;
    logic [MAX_LEN_LIMIT-1:0] code;
  } entry_t;

  // $clog2 that never yields a zero-width vector.
  function automatic int unsigned clog2_min1(int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/huffman_dec_pack_if.sv
// Bundle of the table-programming, bit-input and row-output handshakes.
//   master: drives cfg_*, in/valid_in, flush, ready_out; observes ready_in, out, out_cnt, valid, err
//   slave : the decoder side of the same signals
interface huffman_dec_pack_if
  import huffman_dec_pack_pkg::*;
#(
  parameter int unsigned BW        = 4,
  parameter int unsigned NUM_WORDS = 8,
  parameter int unsigned MAX_LEN   = MAX_LEN_DEF
);

  localparam int unsigned LW   = $clog2(MAX_LEN + 1);
  localparam int unsigned OC_W = $clog2(NUM_WORDS + 1);

  logic                    cfg_we;
  logic [BW-1:0]           cfg_addr;
  logic [LW-1:0]           cfg_len;
  logic [MAX_LEN-1:0]      cfg_code;
  logic                    in;
  logic                    valid_in;
  logic                    ready_in;
  logic                    flush;
  logic [BW*NUM_WORDS-1:0] out;
  logic [OC_W-1:0]         out_cnt;
  logic                    valid;
  logic                    ready_out;
  logic                    err;

  modport master (
    output cfg_we, cfg_addr, cfg_len, cfg_code, in, valid_in, flush, ready_out,
    input  ready_in, out, out_cnt, valid, err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_len, cfg_code, in, valid_in, flush, ready_out,
    output ready_in, out, out_cnt, valid, err
  );

endinterface

// File: rtl/huffman_dec_pack_code_table.sv
// Programmable code table: 2**BW entries, entry i decodes to symbol i.
//   clk, reset              clock, synchronous active-high reset (all entries -> len 0)
//   cfg_we/addr/len/code    write one entry, visible the following cycle
//   bits, nbits             candidate code (right-aligned) and its length
//   hit, symbol             combinational match result; lowest index wins
module huffman_dec_pack_code_table
  import huffman_dec_pack_pkg::*;
#(
  parameter int unsigned BW      = 4,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  localparam int unsigned LW     = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [BW-1:0]      cfg_addr,
  input  logic [LW-1:0]      cfg_len,
  input  logic [MAX_LEN-1:0] cfg_code,
  input  logic [MAX_LEN-1:0] bits,
  input  logic [LW-1:0]      nbits,
  output logic               hit,
  output logic [BW-1:0]      symbol
);

  localparam int unsigned NUM_ENT = 2 ** BW;

  entry_t tbl_q [NUM_ENT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENT; i++) tbl_q[i] <= '0;
    end else if (cfg_we) begin
      tbl_q[cfg_addr].len  <= LEN_W'(cfg_len);
      tbl_q[cfg_addr].code <= MAX_LEN_LIMIT'(cfg_code);
    end
  end

  logic [MAX_LEN_LIMIT-1:0] mask;
  logic [MAX_LEN_LIMIT-1:0] bits_ext;

  // Only the low nbits of a stored code are significant.
  always_comb begin
    mask     = '0;
    bits_ext = MAX_LEN_LIMIT'(bits);
    hit      = 1'b0;
    symbol   = '0;
    for (int j = 0; j < MAX_LEN_LIMIT; j++) mask[j] = (j < int'(nbits));
    // Descending scan so the lowest matching index is the one left standing.
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (tbl_q[i].len == LEN_W'(nbits) && ((tbl_q[i].code ^ bits_ext) & mask) == '0) begin
        hit    = 1'b1;
        symbol = BW'(i);
      end
    end
  end

endmodule

// File: rtl/huffman_dec_pack.sv
// Serial Huffman decoder packing NUM_WORDS symbols per output row.
//   clk, reset  clock, synchronous active-high reset
//   bus         huffman_dec_pack_if.slave: table writes, bit input with valid/ready and flush,
//               row output (out, out_cnt, valid/ready_out) and one-cycle err pulse
module huffman_dec_pack
  import huffman_dec_pack_pkg::*;
#(
  parameter int unsigned BW        = 4,
  parameter int unsigned NUM_WORDS = 8,
  parameter int unsigned MAX_LEN   = MAX_LEN_DEF
) (
  input logic               clk,
  input logic               reset,
  huffman_dec_pack_if.slave bus
);

  localparam int unsigned LW    = $clog2(MAX_LEN + 1);
  localparam int unsigned WC_W  = clog2_min1(NUM_WORDS);
  localparam int unsigned OC_W  = $clog2(NUM_WORDS + 1);
  localparam int unsigned ROW_W = BW * NUM_WORDS;

  logic [MAX_LEN-1:0] acc_q, acc_d;
  logic [LW-1:0]      cnt_q, cnt_d;
  logic [WC_W-1:0]    wc_q, wc_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ROW_W-1:0]   out_q, out_d;
  logic [OC_W-1:0]    out_cnt_q, out_cnt_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] bits;
  logic [LW-1:0]      nbits;
  logic               hit;
  logic [BW-1:0]      symbol;
  logic               last_slot;
  logic               ready_in;
  logic               accept;
  logic               flush_fire;
  logic               completed;

  assign bits      = (acc_q << 1) | MAX_LEN'(bus.in);
  assign nbits     = cnt_q + 1'b1;
  assign last_slot = (wc_q == WC_W'(NUM_WORDS - 1));
  // Stall only when the next symbol could complete a row while the previous one is unconsumed.
  assign ready_in   = !(valid_q && !bus.ready_out && last_slot);
  assign accept     = bus.valid_in && ready_in && !bus.cfg_we;
  assign flush_fire = bus.flush && ready_in && !bus.cfg_we;

  huffman_dec_pack_code_table #(
    .BW      (BW),
    .MAX_LEN (MAX_LEN)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (bus.cfg_we),
    .cfg_addr (bus.cfg_addr),
    .cfg_len  (bus.cfg_len),
    .cfg_code (bus.cfg_code),
    .bits     (bits),
    .nbits    (nbits),
    .hit      (hit),
    .symbol   (symbol)
  );

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    wc_d      = wc_q;
    row_d     = row_q;
    out_d     = out_q;
    out_cnt_d = out_cnt_q;
    valid_d   = valid_q && !bus.ready_out;
    err_d     = 1'b0;
    completed = 1'b0;
    if (bus.cfg_we) begin
      // Soft restart; a pending output row survives.
      acc_d = '0;
      cnt_d = '0;
      wc_d  = '0;
      row_d = '0;
    end else begin
      if (accept) begin
        if (hit) begin
          row_d[wc_q*BW +: BW] = symbol;
          acc_d = '0;
          cnt_d = '0;
          if (last_slot) begin
            out_d     = row_d;
            out_cnt_d = OC_W'(NUM_WORDS);
            valid_d   = 1'b1;
            row_d     = '0;
            wc_d      = '0;
            completed = 1'b1;
          end else begin
            wc_d = wc_q + 1'b1;
          end
        end else if (nbits == LW'(MAX_LEN)) begin
          err_d = 1'b1;
          acc_d = '0;
          cnt_d = '0;
        end else begin
          acc_d = bits;
          cnt_d = nbits;
        end
      end
      // Flush sees the row after this cycle's bit has been decoded.
      if (flush_fire && !completed) begin
        acc_d = '0;
        cnt_d = '0;
        if (wc_d != '0) begin
          out_d     = row_d;
          out_cnt_d = OC_W'(wc_d);
          valid_d   = 1'b1;
          row_d     = '0;
          wc_d      = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      wc_q      <= '0;
      row_q     <= '0;
      out_q     <= '0;
      out_cnt_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      wc_q      <= wc_d;
      row_q     <= row_d;
      out_q     <= out_d;
      out_cnt_q <= out_cnt_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign bus.ready_in = ready_in;
  assign bus.out      = out_q;
  assign bus.out_cnt  = out_cnt_q;
  assign bus.valid    = valid_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_huffman_dec_pack.sv
module tb_huffman_dec_pack;

  localparam int unsigned BW        = 4;
  localparam int unsigned NUM_WORDS = 8;
  localparam int unsigned MAX_LEN   = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  huffman_dec_pack_if #(.BW(BW), .NUM_WORDS(NUM_WORDS), .MAX_LEN(MAX_LEN)) bus ();

  huffman_dec_pack #(.BW(BW), .NUM_WORDS(NUM_WORDS), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] out;
    logic [3:0]  cnt;
  } row_t;

  typedef struct {
    int          nsym;
    logic [31:0] syms;
    bit          fl;
    logic [31:0] exp_out;
    logic [3:0]  exp_cnt;
    bit          emits;
  } vec_t;

  row_t exp_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   failures = 0;
  int   err_seen = 0;
  int   code_val[4] = '{0, 2, 6, 7};
  int   code_len[4] = '{1, 2, 3, 3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted row is compared with the oldest expectation.
  row_t e;
  always @(negedge clk) begin
    if (bus.err === 1'b1) err_seen++;
    if (bus.valid === 1'b1 && bus.ready_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected row: got %0h/%0d expected none", bus.out, bus.out_cnt);
      end else begin
        e = exp_q.pop_front();
        check("row data", bus.out, e.out);
        check("row count", 32'(bus.out_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int budget = 50;
    while (bus.ready_in !== 1'b1 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) check(name, 32'(bus.ready_in), 32'd1);
  endtask

  task automatic send_bit(input logic b);
    bus.in       = b;
    bus.valid_in = 1'b1;
    wait_ready("ready_in timeout (bit)");
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic send_sym(input int s);
    for (int k = code_len[s] - 1; k >= 0; k--) send_bit(code_val[s][k]);
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    wait_ready("ready_in timeout (flush)");
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input int len, input int code);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'(addr);
    bus.cfg_len  = 4'(len);
    bus.cfg_code = 8'(code);
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'd8, 1'b1};
    vecs[1] = '{8, 32'h3210_3210, 1'b0, 32'h3210_3210, 4'd8, 1'b1};
    vecs[2] = '{8, 32'h0011_2233, 1'b0, 32'h0011_2233, 4'd8, 1'b1};
    vecs[3] = '{3, 32'h0000_0210, 1'b1, 32'h0000_0210, 4'd3, 1'b1};
    vecs[4] = '{8, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'd8, 1'b1};
    vecs[5] = '{1, 32'h0000_0003, 1'b1, 32'h0000_0003, 4'd1, 1'b1};
    vecs[6] = '{0, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'd0, 1'b0};
    vecs[7] = '{7, 32'h0111_1111, 1'b1, 32'h0111_1111, 4'd7, 1'b1};

    reset         = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_len   = '0;
    bus.cfg_code  = '0;
    bus.in        = 1'b0;
    bus.valid_in  = 1'b0;
    bus.flush     = 1'b0;
    bus.ready_out = 1'b1;
    idle(2);
    reset = 1'b0;
    check("reset out", bus.out, 32'h0);
    check("reset out_cnt", 32'(bus.out_cnt), 32'd0);
    check("reset valid", 32'(bus.valid), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    check("reset ready_in", 32'(bus.ready_in), 32'd1);

    cfg_write(0, 1, 0);
    cfg_write(1, 2, 2);
    cfg_write(2, 3, 6);
    cfg_write(3, 3, 7);

    // Row latency: valid appears exactly one cycle after the completing bit.
    exp_q.push_back('{32'h0, 4'd8});
    repeat (7) send_bit(1'b0);
    check("t1 valid before last bit", 32'(bus.valid), 32'd0);
    send_bit(1'b0);
    check("t1 valid after last bit", 32'(bus.valid), 32'd1);
    check("t1 out_cnt", 32'(bus.out_cnt), 32'd8);
    idle(2);
    check("t1 drained", exp_q.size(), 0);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].emits) exp_q.push_back('{vecs[v].exp_out, vecs[v].exp_cnt});
      for (int i = 0; i < vecs[v].nsym; i++) send_sym(int'(vecs[v].syms[i*4 +: 4]));
      if (vecs[v].fl) do_flush();
      idle(3);
      check($sformatf("vec%0d drained", v), exp_q.size(), 0);
    end
    check("no err during decoding", err_seen, 0);

    // Backpressure: a pending row plus a full partial row stalls the input, nothing is lost.
    bus.ready_out = 1'b0;
    exp_q.push_back('{32'h0, 4'd8});
    exp_q.push_back('{32'h1111_1111, 4'd8});
    repeat (8) send_bit(1'b0);
    check("t3 row1 valid", 32'(bus.valid), 32'd1);
    repeat (7) send_sym(1);
    check("t3 ready_in low", 32'(bus.ready_in), 32'd0);
    bus.in       = 1'b1;
    bus.valid_in = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("t3 stalled ready_in", 32'(bus.ready_in), 32'd0);
      check("t3 stalled valid", 32'(bus.valid), 32'd1);
    end
    bus.ready_out = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    check("t3 row1 consumed", 32'(bus.valid), 32'd0);
    send_bit(1'b0);
    check("t3 row2 valid", 32'(bus.valid), 32'd1);
    idle(3);
    check("t3 drained", exp_q.size(), 0);

    // Undecodable stream: err after MAX_LEN bits, no symbol.
    cfg_write(3, 0, 0);
    repeat (7) send_bit(1'b1);
    check("t4 err before 8th", 32'(bus.err), 32'd0);
    send_bit(1'b1);
    check("t4 err pulse", 32'(bus.err), 32'd1);
    idle(1);
    check("t4 err one cycle", 32'(bus.err), 32'd0);
    check("t4 err count", err_seen, 1);
    check("t4 no row", 32'(bus.valid), 32'd0);

    // Reset mid-row discards everything, including the table.
    repeat (5) send_bit(1'b0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("t6 valid", 32'(bus.valid), 32'd0);
    check("t6 out", bus.out, 32'h0);
    check("t6 out_cnt", 32'(bus.out_cnt), 32'd0);
    check("t6 ready_in", 32'(bus.ready_in), 32'd1);
    repeat (7) send_bit(1'b0);
    check("t6 err before 8th", 32'(bus.err), 32'd0);
    send_bit(1'b0);
    check("t6 err pulse", 32'(bus.err), 32'd1);
    check("t6 no row", 32'(bus.valid), 32'd0);
    idle(2);
    check("t6 err count", err_seen, 2);
    check("final drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
